// File: rtl/mlp_mul_pkg.sv
// Shared constants and the round-robin pick function for the multiplier share arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: operand/product widths, default multiplier latency, rr_pick() helper.
package mlp_mul_pkg;

   localparam int MUL_A_W     = 16;
   localparam int MUL_B_W     = 28;
   localparam int MUL_P_W     = 44;
   localparam int MUL_LAT_DEF = 4;

   // rr_pick works on a fixed 8-wide request vector so one function serves
   // every legal requester count; unused upper bits are tied low by callers.
   localparam int RR_MAX   = 8;
   localparam int RR_IDX_W = 3;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First asserted bit of valid, searching upward from ptr and wrapping at num.
   // The loop runs from the far end down so the nearest candidate is written last.
   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX-1:0]   valid,
      input logic [RR_IDX_W-1:0] ptr,
      input int                  num
   );
      rr_pick_t res;
      int       cand;
      res = '0;
      for (int k = RR_MAX - 1; k >= 0; k--) begin
         if (k < num) begin
            cand = int'(ptr) + k;
            if (cand >= num) begin
               cand = cand - num;
            end
            if (valid[cand]) begin
               res.found = 1'b1;
               res.idx   = RR_IDX_W'(cand);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mlp_mul_rr_arb.sv
// Round-robin requester pick with a registered rotating priority pointer.
// Latency: grant is combinational; pointer moves on the clock after a grant.
// Backpressure: gnt_en low suppresses the grant and freezes the pointer.
// Ports: clk, reset_n; req_valid in; gnt_en in; gnt_vld/gnt_idx/gnt_onehot out.
module mlp_mul_rr_arb
   import mlp_mul_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               gnt_en,
   output logic               gnt_vld,
   output logic [ID_W-1:0]    gnt_idx,
   output logic [NUM_REQ-1:0] gnt_onehot
);

   logic [ID_W-1:0]   rr_ptr_q;
   logic [ID_W-1:0]   rr_ptr_d;
   logic [RR_MAX-1:0] valid_ext;
   rr_pick_t          pick;

   always_comb begin
      valid_ext              = '0;
      valid_ext[NUM_REQ-1:0] = req_valid;
      pick                   = rr_pick(valid_ext, RR_IDX_W'(rr_ptr_q), NUM_REQ);

      gnt_vld    = pick.found & gnt_en;
      gnt_idx    = ID_W'(pick.idx);
      gnt_onehot = '0;
      if (gnt_vld) begin
         gnt_onehot[gnt_idx] = 1'b1;
      end

      // Priority passes to the requester just after the winner; a request
      // that is dropped before winning leaves the pointer untouched.
      rr_ptr_d = rr_ptr_q;
      if (gnt_vld) begin
         if (int'(gnt_idx) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/mlp_mul_share_arb.sv
// Shares one pipelined signed 16x28 multiplier among NUM_REQ neuron requesters.
// Latency: grant in cycle T -> rsp_valid in T+MUL_LAT, plus one cycle per stall.
// Backpressure: rsp_valid & ~rsp_ready drops mul_ce, freezing pipe and grants.
// Ports: req_valid/req_ready/req_a/req_b (requesters), rsp_* (product out),
//        mul_ce/mul_din0/mul_din1/mul_dout (multiplier), issue_cnt (saturating).
module mlp_mul_share_arb
   import mlp_mul_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*MUL_A_W-1:0] req_a,
   input  logic [NUM_REQ*MUL_B_W-1:0] req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [MUL_P_W-1:0]         rsp_data,
   output logic                       mul_ce,
   output logic [MUL_A_W-1:0]         mul_din0,
   output logic [MUL_B_W-1:0]         mul_din1,
   input  logic [MUL_P_W-1:0]         mul_dout,
   output logic [31:0]                issue_cnt
);

   logic [MUL_LAT-1:0]           vld_pipe_q;
   logic [MUL_LAT-1:0]           vld_pipe_d;
   logic [MUL_LAT-1:0][ID_W-1:0] id_pipe_q;
   logic [MUL_LAT-1:0][ID_W-1:0] id_pipe_d;
   logic [31:0]                  issue_cnt_q;
   logic [31:0]                  issue_cnt_d;

   logic                         stall;
   logic                         gnt_en;
   logic                         gnt_vld;
   logic [ID_W-1:0]              gnt_idx;
   logic [NUM_REQ-1:0]           gnt_onehot;

   // The multiplier has no reset; vld_pipe alone decides whether its output
   // means anything, so clearing vld_pipe discards whatever is in flight.
   assign rsp_valid = vld_pipe_q[MUL_LAT-1];
   assign rsp_id    = id_pipe_q[MUL_LAT-1];
   assign rsp_data  = mul_dout;

   assign stall     = rsp_valid & ~rsp_ready;
   assign mul_ce    = ~stall;
   assign issue_cnt = issue_cnt_q;
   assign req_ready = gnt_onehot;

   // reset_n in the enable keeps every req_ready low while reset is held,
   // even though the arbiter logic itself is combinational.
   assign gnt_en = ~stall & reset_n;

   mlp_mul_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arb (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .gnt_en     (gnt_en),
      .gnt_vld    (gnt_vld),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot)
   );

   // Operands are zeroed on idle cycles so the DSP inputs do not toggle.
   always_comb begin
      mul_din0 = '0;
      mul_din1 = '0;
      if (gnt_vld) begin
         mul_din0 = req_a[int'(gnt_idx)*MUL_A_W +: MUL_A_W];
         mul_din1 = req_b[int'(gnt_idx)*MUL_B_W +: MUL_B_W];
      end
   end

   // Tag/valid pipe advances only with mul_ce so it stays aligned with the
   // multiplier's internal stages through any number of stall cycles.
   always_comb begin
      vld_pipe_d  = vld_pipe_q;
      id_pipe_d   = id_pipe_q;
      issue_cnt_d = issue_cnt_q;
      if (mul_ce) begin
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            id_pipe_d[i]  = id_pipe_q[i-1];
         end
         vld_pipe_d[0] = gnt_vld;
         id_pipe_d[0]  = gnt_idx;
      end
      if (gnt_vld && (issue_cnt_q != 32'hFFFF_FFFF)) begin
         issue_cnt_d = issue_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q  <= '0;
         id_pipe_q   <= '0;
         issue_cnt_q <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         id_pipe_q   <= id_pipe_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

endmodule

// File: tb/tb_mlp_mul_share_arb.sv
// Self-checking bench for mlp_mul_share_arb with a behavioural multiplier.
// A queue-based scoreboard predicts grants, response timing and products.
// Directed scenario tasks add targeted checks on top of the scoreboard.
module tb_mlp_mul_share_arb;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int MUL_LAT = 4;

   logic                  clk;
   logic                  reset_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*16-1:0] req_a;
   logic [NUM_REQ*28-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [43:0]           rsp_data;
   logic                  mul_ce;
   logic [15:0]           mul_din0;
   logic [27:0]           mul_din1;
   logic [43:0]           mul_dout;
   logic [31:0]           issue_cnt;

   int checks   = 0;
   int failures = 0;

   mlp_mul_share_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .mul_ce    (mul_ce),
      .mul_din0  (mul_din0),
      .mul_din1  (mul_din1),
      .mul_dout  (mul_dout),
      .issue_cnt (issue_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: MUL_LAT ce-enabled stages, no reset.
   logic [43:0] mul_pipe [MUL_LAT];
   always @(posedge clk) begin
      if (mul_ce) begin
         mul_pipe[0] <= 44'(longint'($signed(mul_din0)) * longint'($signed(mul_din1)));
         for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
      end
   end
   assign mul_dout = mul_pipe[MUL_LAT-1];

   // ---------------- scoreboard / reference model ----------------
   typedef struct {
      int     id;
      longint prod;
      longint ce_at;
   } exp_t;

   exp_t               sb_q[$];
   bit                 sb_en   = 1'b0;
   int                 m_ptr   = 0;
   logic [31:0]        m_issue = '0;
   longint             ce_cnt  = 0;
   bit                 e_vld;
   bit                 e_stall;
   int                 e_g;
   logic [NUM_REQ-1:0] e_rdy;
   longint             e_a;
   longint             e_b;
   logic [63:0]        e_prod;

   // A request in flight is due once MUL_LAT unstalled cycles have elapsed
   // since its grant cycle; stalled cycles do not count.
   always @(negedge clk) begin
      if (sb_en) begin
         e_vld = (sb_q.size() > 0) && (ce_cnt == sb_q[0].ce_at + MUL_LAT);
         checks++;
         if (rsp_valid !== e_vld) begin
            failures++;
            $display("FAIL sb_rsp_valid t=%0t got=%b exp=%b", $time, rsp_valid, e_vld);
         end
         if (e_vld) begin
            e_prod = sb_q[0].prod;
            checks++;
            if (rsp_id !== 2'(sb_q[0].id)) begin
               failures++;
               $display("FAIL sb_rsp_id t=%0t got=%0d exp=%0d", $time, rsp_id, sb_q[0].id);
            end
            checks++;
            if (rsp_data !== e_prod[43:0]) begin
               failures++;
               $display("FAIL sb_rsp_data t=%0t got=%h exp=%h", $time, rsp_data, e_prod[43:0]);
            end
         end
         e_stall = e_vld && !rsp_ready;
         checks++;
         if (mul_ce !== !e_stall) begin
            failures++;
            $display("FAIL sb_mul_ce t=%0t got=%b exp=%b", $time, mul_ce, !e_stall);
         end
         e_g = -1;
         if (!e_stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (e_g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) e_g = (m_ptr + k) % NUM_REQ;
            end
         end
         e_rdy = '0;
         if (e_g >= 0) e_rdy[e_g] = 1'b1;
         checks++;
         if (req_ready !== e_rdy) begin
            failures++;
            $display("FAIL sb_req_ready t=%0t got=%b exp=%b", $time, req_ready, e_rdy);
         end
         checks++;
         if (e_g >= 0) begin
            if ({mul_din0, mul_din1} !== {req_a[16*e_g +: 16], req_b[28*e_g +: 28]}) begin
               failures++;
               $display("FAIL sb_mul_din t=%0t got=%h/%h exp=%h/%h", $time, mul_din0, mul_din1,
                        req_a[16*e_g +: 16], req_b[28*e_g +: 28]);
            end
            e_a = longint'($signed(req_a[16*e_g +: 16]));
            e_b = longint'($signed(req_b[28*e_g +: 28]));
            sb_q.push_back('{e_g, e_a * e_b, ce_cnt});
            m_ptr = (e_g + 1) % NUM_REQ;
         end else if ({mul_din0, mul_din1} !== 44'd0) begin
            failures++;
            $display("FAIL sb_mul_din_idle t=%0t got=%h/%h exp=0/0", $time, mul_din0, mul_din1);
         end
         checks++;
         if (issue_cnt !== m_issue) begin
            failures++;
            $display("FAIL sb_issue_cnt t=%0t got=%h exp=%h", $time, issue_cnt, m_issue);
         end
         if (e_g >= 0 && m_issue != 32'hFFFF_FFFF) m_issue = m_issue + 32'd1;
         if (e_vld && rsp_ready) void'(sb_q.pop_front());
         if (!e_stall) ce_cnt++;
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops_random();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[16*i +: 16] = 16'($urandom);
         req_b[28*i +: 28] = 28'($urandom);
      end
   endtask

   task automatic model_clear();
      sb_q.delete();
      m_ptr   = 0;
      m_issue = '0;
   endtask

   // Called at posedge+1; returns at posedge+1 with reset released.
   task automatic apply_reset();
      sb_en     = 1'b0;
      req_valid = '0;
      reset_n   = 1'b0;
      tick();
      reset_n = 1'b1;
      model_clear();
      sb_en = 1'b1;
   endtask

   task automatic drain_and_check(input string name);
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (MUL_LAT + 4) tick();
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain outstanding=%0d exp=0", name, sb_q.size());
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      set_ops_random();
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, mul_ce} !== {1'b0, 4'b0000, 1'b1}) begin
         failures++;
         $display("FAIL reset_ctrl got=v%b r%b ce%b exp=v0 r0000 ce1", rsp_valid, req_ready, mul_ce);
      end
      checks++;
      if ({mul_din0, mul_din1, issue_cnt} !== 76'd0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h exp=0", mul_din0, mul_din1, issue_cnt);
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      reset_n   = 1'b1;
      model_clear();
      sb_en = 1'b1;
   endtask

   task automatic test_single();
      req_valid         = 4'b0001;
      req_a[15:0]       = 16'hFFFD;      // -3
      req_b[27:0]       = 28'd100000;
      rsp_ready         = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_grant got=%b exp=0001", req_ready);
      end
      tick();
      req_valid = '0;
      for (int c = 1; c <= MUL_LAT; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== (c == MUL_LAT)) begin
            failures++;
            $display("FAIL single_latency cycle=%0d got=%b exp=%b", c, rsp_valid, c == MUL_LAT);
         end
         if (c == MUL_LAT) begin
            checks++;
            if ({rsp_id, rsp_data} !== {2'd0, 44'(-64'sd300000)}) begin
               failures++;
               $display("FAIL single_rsp got=id%0d %h exp=id0 %h", rsp_id, rsp_data, 44'(-64'sd300000));
            end
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < 8; i++) begin
         set_ops_random();
         @(negedge clk);
         checks++;
         if (req_ready !== 4'(1 << (i % NUM_REQ))) begin
            failures++;
            $display("FAIL rr_order step=%0d got=%b exp=%b", i, req_ready, 4'(1 << (i % NUM_REQ)));
         end
         tick();
      end
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (issue_cnt !== 32'd8) begin
         failures++;
         $display("FAIL rr_issue_cnt got=%0d exp=8", issue_cnt);
      end
      tick();
      drain_and_check("rr");
   endtask

   task automatic test_back_to_back_backpressure();
      rsp_ready = 1'b1;
      req_valid = '1;
      repeat (6) begin
         set_ops_random();
         tick();
      end
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, mul_ce, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL bp_stall cycle=%0d got=v%b ce%b r%b exp=v1 ce0 r0000", c, rsp_valid,
                     mul_ce, req_ready);
         end
         tick();
      end
      rsp_ready = 1'b1;
      repeat (4) begin
         set_ops_random();
         tick();
      end
      drain_and_check("bp");
   endtask

   task automatic test_extremes();
      int got = 0;
      rsp_ready    = 1'b1;
      req_valid    = 4'b0010;
      req_a[31:16] = 16'h8000;           // -32768
      req_b[55:28] = 28'h800_0000;       // -134217728
      tick();
      req_valid    = 4'b0100;
      req_a[47:32] = 16'h7FFF;           // 32767
      req_b[83:56] = 28'h7FF_FFFF;       // 134217727
      tick();
      req_valid = '0;
      for (int c = 0; c < MUL_LAT + 4; c++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            checks++;
            if (got == 0 && {rsp_id, rsp_data} !== {2'd1, 44'h400_0000_0000}) begin
               failures++;
               $display("FAIL ext_min got=id%0d %0d exp=id1 4398046511104", rsp_id, rsp_data);
            end else if (got == 1 && {rsp_id, rsp_data} !== {2'd2, 44'd4397912260609}) begin
               failures++;
               $display("FAIL ext_max got=id%0d %0d exp=id2 4397912260609", rsp_id, rsp_data);
            end
            got++;
         end
         tick();
      end
      checks++;
      if (got != 2) begin
         failures++;
         $display("FAIL ext_count got=%0d exp=2", got);
      end
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      rsp_ready = 1'b1;
      req_valid = '1;
      repeat (3) begin
         set_ops_random();
         tick();
      end
      req_valid = '0;
      tick();
      // three products in flight, the oldest now presented on rsp
      sb_en   = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, req_ready} !== 5'b0) begin
         failures++;
         $display("FAIL mid_reset_async got=v%b r%b exp=v0 r0000", rsp_valid, req_ready);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      sb_en = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_ghost cycle=%0d got=%b exp=0", c, rsp_valid);
         end
         tick();
      end
      req_valid = '1;
      set_ops_random();
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL mid_reset_ptr got=%b exp=0001", req_ready);
      end
      tick();
      drain_and_check("mid_reset");
   endtask

   task automatic test_saturation();
      req_valid = '0;
      rsp_ready = 1'b1;
      force dut.issue_cnt_q = 32'hFFFF_FFFE;
      m_issue = 32'hFFFF_FFFE;
      tick();
      release dut.issue_cnt_q;
      req_valid = 4'b0001;
      repeat (3) begin
         set_ops_random();
         tick();
      end
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (issue_cnt !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL sat_issue_cnt got=%h exp=ffffffff", issue_cnt);
      end
      tick();
      drain_and_check("sat");
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         req_valid = NUM_REQ'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         set_ops_random();
         tick();
      end
      drain_and_check("rand");
   endtask

   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      reset_n   = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back_backpressure();
      test_extremes();
      test_reset_midflight();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
